// File: rtl/text_pkg.sv
// text_pkg
// Shared definitions for the text write controller: screen geometry,
// control-character codes, controller states and the operation codes that
// select which cursor step a STEP cycle issues.
// The clear-screen command is built only when TEXT_CTRL_CLS_EN is defined;
// the CLEAR state stays in the enum so both builds share one encoding.
package text_pkg;

    localparam int COLS  = 80;
    localparam int ROWS  = 48;
    localparam int CELLS = COLS * ROWS;
    localparam logic [11:0] LAST_CELL = 12'(CELLS - 1);

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;

    // Button indices into the pending-request vector; lower index wins.
    localparam int BTN_PS = 0;
    localparam int BTN_PT = 1;
    localparam int BTN_MS = 2;
    localparam int BTN_MT = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        STEP   = 3'd2,
        WAIT   = 3'd3,
        BS_CLR = 3'd4,
        CLEAR  = 3'd5
    } state_t;

    // What the current operation is; decides the STEP pulse and what
    // follows WAIT.
    typedef enum logic [2:0] {
        OP_CHAR = 3'd0,
        OP_LF   = 3'd1,
        OP_CR   = 3'd2,
        OP_BS   = 3'd3,
        OP_PS   = 3'd4,
        OP_PT   = 3'd5,
        OP_MS   = 3'd6,
        OP_MT   = 3'd7
    } op_t;

    function automatic logic [6:0] col_of(input logic [11:0] addr);
        return 7'(addr % 12'(COLS));
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= CH_SPACE) && (c <= CH_TILDE);
    endfunction

endpackage

// File: rtl/btn_pend.sv
// btn_pend
// Rising-edge detector and pending flag for one debounced button.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   btn        : debounced button level
//   clr        : step for this button is being issued this cycle
//   req        : pending request (latched flag, or an edge seen this cycle)
// The edge is visible on req in the same cycle it arrives so a button that
// rises alongside a host character is still served first. Edges arriving
// while the flag is set are absorbed.
module btn_pend (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic clr,
    output logic req
);

    logic hist;
    logic pend;
    logic rise;

    assign rise = btn & ~hist;
    assign req  = pend | rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 1'b0;
            pend <= 1'b0;
        end else begin
            hist <= btn;
            pend <= clr ? 1'b0 : (pend | rise);
        end
    end

endmodule

// File: rtl/text_write_ctrl.sv
// text_write_ctrl
// Turns host characters and cursor buttons into text-memory writes and
// single-cycle step pulses for an external cursor counter on an 80x48 screen.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   ch_valid, ch_data, ch_ready : host character handshake
//   btn_*                     : debounced button levels
//   cur_addr                  : current cursor cell from the counter
//   plus_str .. minus_tab     : step pulses to the counter
//   mem_we, mem_addr, mem_wdata : text memory write port
//   busy                      : high whenever the FSM is not in IDLE
// Handshake: a character transfers on a rising clk edge where ch_valid and
// ch_ready are both high; ch_ready is high only in IDLE with no button
// pending, and never depends on ch_valid.
// Build option: define TEXT_CTRL_CLS_EN to make FF (0x0C) clear the screen.
// Every write and pulse is decoded from the state register, so an
// asynchronous reset silences them immediately.
module text_write_ctrl
    import text_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ch_valid,
    input  logic [7:0]  ch_data,
    output logic        ch_ready,
    input  logic        btn_plus_str,
    input  logic        btn_plus_tab,
    input  logic        btn_minus_str,
    input  logic        btn_minus_tab,
    input  logic [11:0] cur_addr,
    output logic        plus_str,
    output logic        plus_tab,
    output logic        minus_str,
    output logic        minus_tab,
    output logic        mem_we,
    output logic [11:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy
);

    state_t     state, state_n;
    op_t        op, op_n;
    logic [7:0] ch_q, ch_n;
    logic       live;
    logic [3:0] req;
    logic [3:0] clr;
    logic       accept;
    logic       cur_col0;
`ifdef TEXT_CTRL_CLS_EN
    logic [11:0] clr_addr, clr_addr_n;
`endif

    btn_pend u_pend_ps (.clk(clk), .rst_n(rst_n), .btn(btn_plus_str),
                        .clr(clr[BTN_PS]), .req(req[BTN_PS]));
    btn_pend u_pend_pt (.clk(clk), .rst_n(rst_n), .btn(btn_plus_tab),
                        .clr(clr[BTN_PT]), .req(req[BTN_PT]));
    btn_pend u_pend_ms (.clk(clk), .rst_n(rst_n), .btn(btn_minus_str),
                        .clr(clr[BTN_MS]), .req(req[BTN_MS]));
    btn_pend u_pend_mt (.clk(clk), .rst_n(rst_n), .btn(btn_minus_tab),
                        .clr(clr[BTN_MT]), .req(req[BTN_MT]));

    assign cur_col0 = (col_of(cur_addr) == 7'd0);
    // live keeps ch_ready low while reset is held even though state is IDLE.
    assign ch_ready = live && (state == IDLE) && (req == 4'b0000);
    assign accept   = ch_valid && ch_ready;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= OP_CHAR;
            ch_q     <= 8'h00;
            live     <= 1'b0;
`ifdef TEXT_CTRL_CLS_EN
            clr_addr <= 12'd0;
`endif
        end else begin
            state    <= state_n;
            op       <= op_n;
            ch_q     <= ch_n;
            live     <= 1'b1;
`ifdef TEXT_CTRL_CLS_EN
            clr_addr <= clr_addr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        op_n      = op;
        ch_n      = ch_q;
        clr       = 4'b0000;
        plus_str  = 1'b0;
        plus_tab  = 1'b0;
        minus_str = 1'b0;
        minus_tab = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 12'd0;
        mem_wdata = 8'h00;
`ifdef TEXT_CTRL_CLS_EN
        clr_addr_n = clr_addr;
`endif
        case (state)
            IDLE: begin
                // Buttons first, fixed priority; a character is taken only
                // when nothing is pending (ch_ready already encodes that).
                if (req[BTN_PS]) begin
                    op_n    = OP_PS;
                    state_n = STEP;
                end else if (req[BTN_PT]) begin
                    op_n    = OP_PT;
                    state_n = STEP;
                end else if (req[BTN_MS]) begin
                    op_n    = OP_MS;
                    state_n = STEP;
                end else if (req[BTN_MT]) begin
                    op_n    = OP_MT;
                    state_n = STEP;
                end else if (accept) begin
                    if (is_printable(ch_data)) begin
                        ch_n    = ch_data;
                        op_n    = OP_CHAR;
                        state_n = WRITE;
                    end else if (ch_data == CH_LF) begin
                        op_n    = OP_LF;
                        state_n = STEP;
                    end else if (ch_data == CH_CR) begin
                        // Already at column 0: nothing to do, stay in IDLE.
                        if (!cur_col0) begin
                            op_n    = OP_CR;
                            state_n = STEP;
                        end
                    end else if (ch_data == CH_BS) begin
                        op_n    = OP_BS;
                        state_n = STEP;
`ifdef TEXT_CTRL_CLS_EN
                    end else if (ch_data == CH_FF) begin
                        clr_addr_n = 12'd0;
                        state_n    = CLEAR;
`endif
                    end
                    // Any other code is consumed with no effect.
                end
            end

            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = ch_q;
                state_n   = STEP;
            end

            STEP: begin
                case (op)
                    OP_CHAR, OP_PS:        plus_str  = 1'b1;
                    OP_LF, OP_PT:          plus_tab  = 1'b1;
                    OP_CR, OP_BS, OP_MS:   minus_str = 1'b1;
                    OP_MT:                 minus_tab = 1'b1;
                    default:               plus_str  = 1'b0;
                endcase
                clr[BTN_PS] = (op == OP_PS);
                clr[BTN_PT] = (op == OP_PT);
                clr[BTN_MS] = (op == OP_MS);
                clr[BTN_MT] = (op == OP_MT);
                state_n     = WAIT;
            end

            WAIT: begin
                // cur_addr already reflects the pulse issued in STEP.
                if ((op == OP_CR) && !cur_col0) begin
                    state_n = STEP;
                end else if (op == OP_BS) begin
                    state_n = BS_CLR;
                end else begin
                    state_n = IDLE;
                end
            end

            BS_CLR: begin
                mem_we    = 1'b1;
                mem_addr  = cur_addr;
                mem_wdata = CH_SPACE;
                state_n   = IDLE;
            end

`ifdef TEXT_CTRL_CLS_EN
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_addr;
                mem_wdata = CH_SPACE;
                if (clr_addr == LAST_CELL) begin
                    state_n = IDLE;
                end else begin
                    clr_addr_n = clr_addr + 12'd1;
                end
            end
`endif

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
